cache_2way: RTL

CACHE_2WAY -- requirements
Module: cache_2way

---
 rtl/cache_pkg.sv | 23 ++
 rtl/cache_way.sv | 58 +++++
 rtl/cache_2way.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : cache_pkg
// Brief  : Shared FSM state encoding and default geometry for cache_2way.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package cache_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_INDEX_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_MEM_RD = 3'd2,
    S_MEM_WR = 3'd3,
    S_RESP   = 3'd4,
    S_FLUSH  = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cache_way.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : cache_way
// Brief  : One way of storage: valid/tag/data per set, async read, sync write.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module cache_way
  import cache_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TAG_W   = DEF_ADDR_W - DEF_INDEX_W - 2,
  parameter int INDEX_W = DEF_INDEX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] i_idx,
  input  logic               i_fill,
  input  logic               i_data_we,
  input  logic               i_clr,
  input  logic [TAG_W-1:0]   i_tag,
  input  logic [DATA_W-1:0]  i_data,
  output logic               o_valid,
  output logic [TAG_W-1:0]   o_tag,
  output logic [DATA_W-1:0]  o_data
);

  localparam int SETS = 2 ** INDEX_W;

  logic [SETS-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [DATA_W-1:0] r_data [SETS];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_clr) begin
      r_valid[i_idx] <= 1'b0;
    end else if (i_fill) begin
      r_valid[i_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: a line is only observed through its valid bit.
  always_ff @(posedge clk) begin
    if (i_fill) begin
      r_tag[i_idx]  <= i_tag;
      r_data[i_idx] <= i_data;
    end else if (i_data_we) begin
      r_data[i_idx] <= i_data;
    end
  end

  assign o_valid = r_valid[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_data  = r_data[i_idx];

endmodule
`default_nettype wire

// File: rtl/cache_2way.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : cache_2way
// Brief  : 2-way set-associative write-through, no-write-allocate cache.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module cache_2way
  import cache_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int INDEX_W     = DEF_INDEX_W,
  parameter int MEM_LAT_MAX = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              flush,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic              mem_valid,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SETS  = 2 ** INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_hit;
  logic [INDEX_W-1:0]  r_flush_cnt;
  logic [SETS-1:0]     r_lru;

  logic [INDEX_W-1:0]  w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic                w_v0, w_v1;
  logic [TAG_W-1:0]    w_t0, w_t1;
  logic [DATA_W-1:0]   w_d0, w_d1;
  logic                w_hit0, w_hit1, w_hit;
  logic                w_victim;
  logic [DATA_W-1:0]   w_way_data;
  logic                w_fill0, w_fill1, w_dwe0, w_dwe1, w_clr;
  logic                w_unused;

  assign w_unused = (MEM_LAT_MAX != 0);

  assign w_idx      = (r_state == S_FLUSH) ? r_flush_cnt : r_addr[INDEX_W+1:2];
  assign w_tag      = r_addr[ADDR_W-1:INDEX_W+2];
  assign w_hit0     = w_v0 && (w_t0 == w_tag);
  assign w_hit1     = w_v1 && (w_t1 == w_tag);
  assign w_hit      = w_hit0 || w_hit1;
  // Empty ways are filled before anything valid is evicted.
  assign w_victim   = !w_v0 ? 1'b0 : (!w_v1 ? 1'b1 : r_lru[w_idx]);
  assign w_way_data = (r_state == S_MEM_RD) ? mem_rdata : r_wdata;

  cache_way #(.DATA_W(DATA_W), .TAG_W(TAG_W), .INDEX_W(INDEX_W)) u_way0 (
    .clk       (clk),
    .rst       (rst),
    .i_idx     (w_idx),
    .i_fill    (w_fill0),
    .i_data_we (w_dwe0),
    .i_clr     (w_clr),
    .i_tag     (w_tag),
    .i_data    (w_way_data),
    .o_valid   (w_v0),
    .o_tag     (w_t0),
    .o_data    (w_d0)
  );

  cache_way #(.DATA_W(DATA_W), .TAG_W(TAG_W), .INDEX_W(INDEX_W)) u_way1 (
    .clk       (clk),
    .rst       (rst),
    .i_idx     (w_idx),
    .i_fill    (w_fill1),
    .i_data_we (w_dwe1),
    .i_clr     (w_clr),
    .i_tag     (w_tag),
    .i_data    (w_way_data),
    .o_valid   (w_v1),
    .o_tag     (w_t1),
    .o_data    (w_d1)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fill0     = 1'b0;
    w_fill1     = 1'b0;
    w_dwe0      = 1'b0;
    w_dwe1      = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (flush)          w_state_nxt = S_FLUSH;
        else if (req_valid) w_state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (r_wr) begin
          w_dwe0      = w_hit0;
          w_dwe1      = w_hit1;
          w_state_nxt = S_MEM_WR;
        end else begin
          w_state_nxt = w_hit ? S_RESP : S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        if (mem_done) begin
          w_fill0     = !w_victim;
          w_fill1     = w_victim;
          w_state_nxt = S_RESP;
        end
      end
      S_MEM_WR: begin
        if (mem_done) w_state_nxt = S_RESP;
      end
      S_RESP: w_state_nxt = S_IDLE;
      S_FLUSH: begin
        w_clr = 1'b1;
        if (&r_flush_cnt) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_hit       <= 1'b0;
      r_flush_cnt <= '0;
      r_lru       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!flush && req_valid) begin
            r_wr    <= req_wr;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_rdata <= '0;
            r_hit   <= 1'b0;
          end
        end
        S_LOOKUP: begin
          r_hit <= w_hit;
          if (w_hit) r_lru[w_idx] <= w_hit0;
          if (w_hit && !r_wr) r_rdata <= w_hit1 ? w_d1 : w_d0;
        end
        S_MEM_RD: begin
          if (mem_done) begin
            r_rdata      <= mem_rdata;
            r_lru[w_idx] <= ~w_victim;
          end
        end
        S_FLUSH: begin
          r_lru[w_idx] <= 1'b0;
          r_flush_cnt  <= r_flush_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE) && !flush;
  assign resp_valid = (r_state == S_RESP);
  assign resp_hit   = r_hit;
  assign resp_rdata = r_rdata;
  assign mem_valid  = (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign mem_wr     = (r_state == S_MEM_WR);
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;

endmodule
`default_nettype wire
